gat_debug_monitor: RTL and testbench
====================================

Name: gat_debug_monitor

Overview:
- Parametrised on-chip debug monitor for the GAT accelerator; observes NUM_CH pipeline events (SPMM/DMVM/softmax/aggregator valid/ready pulses).
- Keeps sticky flags, per-channel saturating event counters, a run-cycle counter and address-triggered data capture slots.
- All results are read through one 32-bit indexed readback port, which feeds the board debug registers.

Parameters:
- NUM_CH, 8, number of observed single-bit event channels
- CNT_W, 32, width of cycle and event counters (≤32)
- NUM_CAP, 2, number of address-triggered capture slots
- ADDR_W, 16, width of trigger address bus
- DATA_W, 32, width of captured data (≤32)
- SEL_W, 5, readback index width; must satisfy 2^SEL_W ≥ 2+NUM_CH+2·NUM_CAP

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  arm pulse: IDLE→RUN
- freeze_i  in  1  stop pulse: RUN→FROZEN
- clr_i  in  1  synchronous clear of all statistics, returns to IDLE
- evt_i  in  NUM_CH  event strobes, one per channel
- trig_vld_i  in  1  trigger address/data valid
- trig_addr_i  in  ADDR_W  observed BRAM write/read address
- cap_data_i  in  DATA_W  data sampled on trigger match
- cap_match_i  in  NUM_CAP×ADDR_W  per-slot match address (quasi-static config)
- rd_sel_i  in  SEL_W  readback index
- rd_data_o  out  32  registered readback word
- state_o  out  2  0=IDLE, 1=RUN, 2=FROZEN
- sticky_o  out  NUM_CH  sticky OR of evt_i since last clear

Behaviour:
- Reset: state IDLE; all counters, sticky, capture data, capture-valid bits, rd_data_o = 0.
- FSM:
  - IDLE→RUN on start_i.
  - RUN→FROZEN on freeze_i, or when the cycle counter reaches all-ones.
  - FROZEN→RUN on start_i; statistics are kept, not cleared.
  - clr_i from any state → IDLE and zero everything; clr_i has priority over start_i/freeze_i in the same cycle.
- Sticky flags: set in any state, including IDLE (bring-up visibility), and cleared only by clr_i/reset. sticky_o is registered and reflects evt_i one cycle later.
- Cycle counter: increments every RUN cycle; saturates at all-ones, which also forces FROZEN.
- Event counter[i]: increments on each RUN cycle with evt_i[i]=1; saturates at all-ones and never wraps.
- Capture slot k: in RUN, trig_vld_i && trig_addr_i==cap_match_i[k] && !cap_vld[k] → store cap_data_i and set cap_vld[k].
  - First match wins; later matches are ignored until clr_i.
  - Several slots may capture in the same cycle.
- Readback (1-cycle latency, rd_data_o registered, zero-extended to 32 bits):
  - sel 0: {cap_vld[NUM_CAP-1:0], sticky, state} packed LSB-first.
  - sel 1: cycle counter.
  - sel 2..1+NUM_CH: event counters.
  - next NUM_CAP indices: capture data.
  - next NUM_CAP indices: timestamps (see Optional Feature).
  - Indices out of range read 0.
- Same-cycle event and read: the read returns the pre-update value.

Optional Feature:
- Macro: GAT_DBG_TIMESTAMP_EN.
- Defined: each capture slot also latches the current cycle counter value at its capture cycle; readable at the timestamp indices.
- Undefined: no timestamp registers are synthesised; those indices read 0.

Decomposition:
- Package gat_debug_pkg holds:
  - state enum dbg_state_e (IDLE/RUN/FROZEN);
  - readback base-index localparams (SEL_STATUS=0, SEL_CYCLE=1, SEL_EVT_BASE=2);
  - a sat_inc helper function.
- One natural sub-module, gat_dbg_sat_counter (width param, clr, inc, saturating), instantiated for the cycle counter and per channel.

Test Plan:
- Reset, then start_i, then 10 RUN cycles with evt_i[0]=1 every cycle and evt_i[3]=1 on 3 cycles → sel1=10, sel2=10, sel5=3, state_o=1.
- evt_i[1] pulse while IDLE → sticky_o[1]=1 next cycle; sel3=0; state_o stays 0.
- In RUN, cap_match_i[0]=10: trig_addr 10 with data 0xABCD, then addr 10 with data 0x1234 → slot 0 reads 0xABCD; cap_vld[0]=1 in sel0.
- CNT_W=4: run 20 cycles with evt_i[0] held high → counters saturate at 15; state_o=2 after cycle counter hits 15.
- clr_i and start_i asserted together in RUN → state_o=0; all readbacks 0 on the following read.
- With GAT_DBG_TIMESTAMP_EN, capture on RUN cycle 7 → timestamp index reads 7; rebuilt without the macro → reads 0.

Source files
------------

// File: rtl/gat_debug_pkg.sv
// gat_debug_pkg: shared state encoding, readback indices and saturating-increment helper for the GAT debug monitor
package gat_debug_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } dbg_state_e;

  localparam int SEL_STATUS   = 0;
  localparam int SEL_CYCLE    = 1;
  localparam int SEL_EVT_BASE = 2;

  // increment v, holding at the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] mx;
    mx = (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    return (v >= mx) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gat_dbg_sat_counter.sv
// gat_dbg_sat_counter: W-bit counter with synchronous clear that sticks at all-ones
module gat_dbg_sat_counter
  import gat_debug_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // clear wins over increment; increment never wraps past all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc) r_q <= W'(sat_inc(32'(r_q), W));

  assign o_q = r_q;

endmodule

// File: rtl/gat_debug_monitor.sv
// gat_debug_monitor: event/cycle statistics, sticky flags and address-triggered captures behind one indexed readback port
// Optional capture timestamps are built when GAT_DBG_TIMESTAMP_EN is defined.
module gat_debug_monitor
  import gat_debug_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 32,
  parameter int NUM_CAP = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      freeze_i,
  input  logic                      clr_i,
  input  logic [NUM_CH-1:0]         evt_i,
  input  logic                      trig_vld_i,
  input  logic [ADDR_W-1:0]         trig_addr_i,
  input  logic [DATA_W-1:0]         cap_data_i,
  input  logic [NUM_CAP*ADDR_W-1:0] cap_match_i,
  input  logic [SEL_W-1:0]          rd_sel_i,
  output logic [31:0]               rd_data_o,
  output logic [1:0]                state_o,
  output logic [NUM_CH-1:0]         sticky_o
);

  localparam int SEL_CAP_BASE = SEL_EVT_BASE + NUM_CH;
  localparam int SEL_TS_BASE  = SEL_CAP_BASE + NUM_CAP;
  localparam int ST_W         = 2 + NUM_CH + NUM_CAP;

  dbg_state_e        r_state;
  logic [NUM_CH-1:0] r_sticky;
  logic [NUM_CAP-1:0] r_cap_vld;
  logic [DATA_W-1:0] r_cap [NUM_CAP];
  logic [31:0]       r_rd;
  logic              w_run;
  logic [CNT_W-1:0]  w_cyc;
  logic [CNT_W-1:0]  w_evt [NUM_CH];
  logic [NUM_CAP-1:0] w_hit;
  logic [ST_W-1:0]   w_status;
  logic [31:0]       w_rd;

  assign w_run = (r_state == RUN);

  gat_dbg_sat_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clr_i),
    .i_inc (w_run),
    .o_q   (w_cyc)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_evt
    gat_dbg_sat_counter #(.W(CNT_W)) u_evt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (clr_i),
      .i_inc (w_run && evt_i[g]),
      .o_q   (w_evt[g])
    );
  end

  // run control; a saturated cycle counter freezes the run by itself
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else if (clr_i) r_state <= IDLE;
    else
      case (r_state)
        IDLE:    if (start_i) r_state <= RUN;
        RUN:     if (freeze_i || &w_cyc) r_state <= FROZEN;
        FROZEN:  if (start_i) r_state <= RUN;
        default: r_state <= IDLE;
      endcase

  // sticky flags collect events in every state so bring-up sees activity before arming
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sticky <= '0;
    else r_sticky <= clr_i ? '0 : r_sticky | evt_i;

  // a slot fires only once per clear: the first matching address wins
  always_comb
    for (int k = 0; k < NUM_CAP; k++)
      w_hit[k] = w_run && trig_vld_i && !r_cap_vld[k] &&
                 (trig_addr_i == cap_match_i[k*ADDR_W +: ADDR_W]);

  // latch capture data and valid bits for every slot that fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cap_vld <= '0;
      for (int k = 0; k < NUM_CAP; k++) r_cap[k] <= '0;
    end else if (clr_i) begin
      r_cap_vld <= '0;
      for (int k = 0; k < NUM_CAP; k++) r_cap[k] <= '0;
    end else
      for (int k = 0; k < NUM_CAP; k++)
        if (w_hit[k]) begin
          r_cap_vld[k] <= 1'b1;
          r_cap[k]     <= cap_data_i;
        end

`ifdef GAT_DBG_TIMESTAMP_EN
  logic [CNT_W-1:0] r_ts [NUM_CAP];
  // stamp with the cycle count including the capture cycle itself
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < NUM_CAP; k++) r_ts[k] <= '0;
    else if (clr_i) for (int k = 0; k < NUM_CAP; k++) r_ts[k] <= '0;
    else
      for (int k = 0; k < NUM_CAP; k++)
        if (w_hit[k]) r_ts[k] <= CNT_W'(sat_inc(32'(w_cyc), CNT_W));
`endif

  assign w_status = {r_cap_vld, r_sticky, r_state};

  // readback mux over current register values; unmatched indices fall through to zero
  always_comb begin
    w_rd = '0;
    if (rd_sel_i == SEL_W'(SEL_STATUS)) w_rd = 32'(w_status);
    if (rd_sel_i == SEL_W'(SEL_CYCLE)) w_rd = 32'(w_cyc);
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel_i == SEL_W'(SEL_EVT_BASE + i)) w_rd = 32'(w_evt[i]);
    for (int k = 0; k < NUM_CAP; k++) begin
      if (rd_sel_i == SEL_W'(SEL_CAP_BASE + k)) w_rd = 32'(r_cap[k]);
`ifdef GAT_DBG_TIMESTAMP_EN
      if (rd_sel_i == SEL_W'(SEL_TS_BASE + k)) w_rd = 32'(r_ts[k]);
`endif
    end
  end

  // registered readback so the board registers see a clean, pre-update snapshot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rd <= '0;
    else r_rd <= clr_i ? '0 : w_rd;

  assign rd_data_o = r_rd;
  assign state_o   = r_state;
  assign sticky_o  = r_sticky;

endmodule

// File: tb/tb_gat_debug_monitor.sv
// tb_gat_debug_monitor: directed plan plus random traffic on a full-width and a 4-bit-counter monitor, checked against a rule-level model
module tb_gat_debug_monitor;

  localparam int NC = 8;
  localparam int NK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        freeze_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [7:0]  evt_i = '0;
  logic        trig_vld_i = 1'b0;
  logic [15:0] trig_addr_i = '0;
  logic [31:0] cap_data_i = '0;
  logic [31:0] cap_match_i = {16'd20, 16'd10};
  logic [4:0]  rd_sel_i = '0;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  st_a, st_b;
  logic [7:0]  sk_a, sk_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gat_debug_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .freeze_i(freeze_i), .clr_i(clr_i),
    .evt_i(evt_i), .trig_vld_i(trig_vld_i), .trig_addr_i(trig_addr_i), .cap_data_i(cap_data_i),
    .cap_match_i(cap_match_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_a), .state_o(st_a), .sticky_o(sk_a)
  );

  gat_debug_monitor #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .freeze_i(freeze_i), .clr_i(clr_i),
    .evt_i(evt_i), .trig_vld_i(trig_vld_i), .trig_addr_i(trig_addr_i), .cap_data_i(cap_data_i),
    .cap_match_i(cap_match_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_b), .state_o(st_b), .sticky_o(sk_b)
  );

  // model state per instance: 0 = full width, 1 = 4-bit counters
  logic [31:0] mx [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          m_st  [2];
  logic [31:0] m_cyc [2];
  logic [31:0] m_evt [2][NC];
  logic [7:0]  m_sk  [2];
  logic        m_vld [2][NK];
  logic [31:0] m_cap [2][NK];
  logic [31:0] m_ts  [2][NK];
  logic [31:0] m_rd  [2];

  function automatic logic [31:0] rb(int m, int sel);
    logic [31:0] r;
    r = 0;
    if (sel == 0) begin
      r = 32'(m_st[m]) + (32'(m_sk[m]) << 2);
      for (int k = 0; k < NK; k++) if (m_vld[m][k]) r += 32'd1 << (2 + NC + k);
    end else if (sel == 1) r = m_cyc[m];
    else if (sel >= 2 && sel < 2 + NC) r = m_evt[m][sel-2];
    else if (sel >= 2 + NC && sel < 2 + NC + NK) r = m_cap[m][sel-2-NC];
`ifdef GAT_DBG_TIMESTAMP_EN
    else if (sel >= 2 + NC + NK && sel < 2 + NC + 2 * NK) r = m_ts[m][sel-2-NC-NK];
`endif
    return r;
  endfunction

  task automatic mzero(int m);
    m_st[m] = 0; m_cyc[m] = 0; m_sk[m] = 0; m_rd[m] = 0;
    for (int i = 0; i < NC; i++) m_evt[m][i] = 0;
    for (int k = 0; k < NK; k++) begin m_vld[m][k] = 0; m_cap[m][k] = 0; m_ts[m][k] = 0; end
  endtask

  task automatic mstep();
    logic [31:0] oldc, newc;
    for (int m = 0; m < 2; m++) begin
      if (clr_i) mzero(m);
      else begin
        m_rd[m] = rb(m, int'(rd_sel_i));
        oldc = m_cyc[m];
        newc = (oldc < mx[m]) ? oldc + 1 : oldc;
        if (m_st[m] == 1) begin
          for (int k = 0; k < NK; k++)
            if (trig_vld_i && trig_addr_i == cap_match_i[k*16 +: 16] && !m_vld[m][k]) begin
              m_vld[m][k] = 1; m_cap[m][k] = cap_data_i; m_ts[m][k] = newc;
            end
          for (int i = 0; i < NC; i++)
            if (evt_i[i] && m_evt[m][i] < mx[m]) m_evt[m][i]++;
          m_cyc[m] = newc;
        end
        m_sk[m] |= evt_i;
        if (m_st[m] == 0 && start_i) m_st[m] = 1;
        else if (m_st[m] == 1 && (freeze_i || oldc == mx[m])) m_st[m] = 2;
        else if (m_st[m] == 2 && start_i) m_st[m] = 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("a_state", 32'(st_a), m_st[0]);
    chk("a_sticky", 32'(sk_a), 32'(m_sk[0]));
    chk("a_rd", rd_a, m_rd[0]);
    chk("b_state", 32'(st_b), m_st[1]);
    chk("b_sticky", 32'(sk_b), 32'(m_sk[1]));
    chk("b_rd", rd_b, m_rd[1]);
  endtask

  task automatic cyc1();
    mstep();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic clr_start();
    clr_i = 1; cyc1(); clr_i = 0;
    start_i = 1; cyc1(); start_i = 0;
  endtask

  initial begin
    mzero(0); mzero(1);
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1;

    evt_i = 8'h02; cyc1(); evt_i = 0;
    chk("idle_sticky1", 32'(sk_a[1]), 32'd1);
    rd_sel_i = 3; cyc1();
    chk("idle_sel3", rd_a, 32'd0);
    chk("idle_state", 32'(st_a), 32'd0);

    clr_start();
    for (int c = 0; c < 10; c++) begin
      evt_i = 8'h01 | ((c % 3 == 2) ? 8'h08 : 8'h00);
      cyc1();
    end
    evt_i = 0;
    chk("run_state", 32'(st_a), 32'd1);
    rd_sel_i = 1; freeze_i = 1; cyc1(); freeze_i = 0;
    chk("sel1_cycles", rd_a, 32'd10);
    rd_sel_i = 2; cyc1();
    chk("sel2_evt0", rd_a, 32'd10);
    rd_sel_i = 5; cyc1();
    chk("sel5_evt3", rd_a, 32'd3);

    clr_start();
    trig_vld_i = 1; trig_addr_i = 16'd10; cap_data_i = 32'hABCD; cyc1();
    cap_data_i = 32'h1234; cyc1();
    trig_vld_i = 0;
    rd_sel_i = 10; cyc1();
    chk("cap0_first", rd_a, 32'hABCD);
    rd_sel_i = 0; cyc1();
    chk("cap0_vld", 32'(rd_a[10]), 32'd1);

    clr_start();
    evt_i = 8'h01;
    repeat (20) cyc1();
    evt_i = 0;
    chk("sat_b_frozen", 32'(st_b), 32'd2);
    chk("sat_a_run", 32'(st_a), 32'd1);
    rd_sel_i = 1; cyc1();
    chk("sat_b_cyc", rd_b, 32'd15);
    chk("sat_a_cyc", rd_a, 32'd20);
    rd_sel_i = 2; cyc1();
    chk("sat_b_evt0", rd_b, 32'd15);

    clr_start();
    repeat (6) cyc1();
    trig_vld_i = 1; trig_addr_i = 16'd20; cap_data_i = 32'h55; cyc1();
    trig_vld_i = 0;
    rd_sel_i = 13; cyc1();
`ifdef GAT_DBG_TIMESTAMP_EN
    chk("ts_slot1", rd_a, 32'd7);
`else
    chk("ts_slot1", rd_a, 32'd0);
`endif

    clr_i = 1; start_i = 1; cyc1(); clr_i = 0; start_i = 0;
    chk("clr_state_a", 32'(st_a), 32'd0);
    chk("clr_state_b", 32'(st_b), 32'd0);
    for (int s = 0; s < 16; s++) begin
      rd_sel_i = 5'(s); cyc1();
      chk("clr_rd_a", rd_a, 32'd0);
      chk("clr_rd_b", rd_b, 32'd0);
    end

    for (int n = 0; n < 1500; n++) begin
      start_i     = ($urandom % 8) == 0;
      freeze_i    = ($urandom % 16) == 0;
      clr_i       = ($urandom % 64) == 0;
      evt_i       = 8'($urandom) & 8'($urandom);
      trig_vld_i  = ($urandom % 4) == 0;
      case ($urandom % 3)
        0: trig_addr_i = 16'd10;
        1: trig_addr_i = 16'd20;
        default: trig_addr_i = 16'($urandom);
      endcase
      cap_data_i  = $urandom;
      rd_sel_i    = 5'($urandom);
      cyc1();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
